// File: rtl/clock_input_pkg.sv
// Shared constants for the push-button front end: default timing and channel map.
// Channel indices select a button within the NUM_BTN-wide debounced vector.
package clock_input_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int BLINK_DIV_DEF       = 50000000;

   localparam int NUM_BTN = 4;
   localparam int CH_DISP = 0;
   localparam int CH_SEC  = 1;
   localparam int CH_MIN  = 2;
   localparam int CH_HOUR = 3;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, then a stability counter that accepts a new level.
// A level held steady from edge k changes `pressed` on edge k+1+DEBOUNCE_CYCLES; no backpressure.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int RAW_ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic pressed
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          w_norm;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_state;
   logic [CW-1:0] r_cnt;

   // Normalise so that 1 always means "pressed" from the synchronizer onward.
   assign w_norm = (RAW_ACTIVE_LOW != 0) ? ~raw : raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= w_norm;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_state) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_state <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign pressed = r_state;

endmodule

// File: rtl/clock_input_conditioner.sv
// Board-pin front end for control_unit: four debounced buttons, display press strobe, blink tick.
// display pulses one cycle after the debounced press; blink_tick every BLINK_DIV cycles.
module clock_input_conditioner
   import clock_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int BLINK_DIV       = BLINK_DIV_DEF,
   parameter int RAW_ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_display_raw,
   input  logic btn_sec_day_raw,
   input  logic btn_min_month_raw,
   input  logic btn_hour_year_raw,
   output logic display,
   output logic setup_second_day,
   output logic setup_minute_month,
   output logic setup_hour_year,
   output logic blink_tick
);

   localparam int            BW         = $clog2(BLINK_DIV);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [NUM_BTN-1:0] w_raw;
   logic [NUM_BTN-1:0] w_pressed;
   logic               r_disp_prev;
   logic               r_display;
   logic [BW-1:0]      r_bcnt;
   logic               r_blink;

   assign w_raw[CH_DISP] = btn_display_raw;
   assign w_raw[CH_SEC]  = btn_sec_day_raw;
   assign w_raw[CH_MIN]  = btn_min_month_raw;
   assign w_raw[CH_HOUR] = btn_hour_year_raw;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .raw     (w_raw[g]),
         .pressed (w_pressed[g])
      );
   end

   // Rising edge of the debounced display level; holding or releasing emits nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp_prev <= 1'b0;
         r_display   <= 1'b0;
      end else begin
         r_disp_prev <= w_pressed[CH_DISP];
         r_display   <= w_pressed[CH_DISP] & ~r_disp_prev;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bcnt  <= '0;
         r_blink <= 1'b0;
      end else begin
         r_blink <= (r_bcnt == BLINK_LAST);
         if (r_bcnt == BLINK_LAST) begin
            r_bcnt <= '0;
         end else begin
            r_bcnt <= r_bcnt + BW'(1);
         end
      end
   end

   assign display            = r_display;
   assign setup_second_day   = ~w_pressed[CH_SEC];
   assign setup_minute_month = ~w_pressed[CH_MIN];
   assign setup_hour_year    = ~w_pressed[CH_HOUR];
   assign blink_tick         = r_blink;

endmodule

// File: tb/tb_clock_input_conditioner.sv
// Directed bench for clock_input_conditioner with DEBOUNCE_CYCLES=4, BLINK_DIV=8, active-low raw.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_clock_input_conditioner;

   localparam int DEB = 4;
   localparam int DIV = 8;
   // Raw change first sampled on edge k shows on the outputs after edge k+1+DEB.
   localparam int LAT = DEB + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_display_raw   = 1'b1;
   logic btn_sec_day_raw   = 1'b1;
   logic btn_min_month_raw = 1'b1;
   logic btn_hour_year_raw = 1'b1;
   logic display;
   logic setup_second_day;
   logic setup_minute_month;
   logic setup_hour_year;
   logic blink_tick;

   int n_checks = 0;
   int n_fail   = 0;
   int blink_n  = 0;

   clock_input_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .BLINK_DIV       (DIV),
      .RAW_ACTIVE_LOW  (1)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .btn_display_raw    (btn_display_raw),
      .btn_sec_day_raw    (btn_sec_day_raw),
      .btn_min_month_raw  (btn_min_month_raw),
      .btn_hour_year_raw  (btn_hour_year_raw),
      .display            (display),
      .setup_second_day   (setup_second_day),
      .setup_minute_month (setup_minute_month),
      .setup_hour_year    (setup_hour_year),
      .blink_tick         (blink_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Blink phase is counted from reset release: tick after every DIV-th edge.
   always @(posedge clk) begin
      if (rst) blink_n = 0;
      else     blink_n = blink_n + 1;
      #1;
      check("blink_tick", blink_tick, (blink_n > 0) && (blink_n % DIV == 0));
   end

   task automatic check_setups(input string tag, input logic sec, input logic mn, input logic hr);
      check({tag, ".sec"},  setup_second_day,   sec);
      check({tag, ".min"},  setup_minute_month, mn);
      check({tag, ".hour"}, setup_hour_year,    hr);
   endtask

   initial begin
      // 1: reset values, then free-running blink
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst.display", display, 1'b0);
         check_setups("rst", 1'b1, 1'b1, 1'b1);
      end
      rst = 1'b0;
      for (int i = 0; i < 3 * DIV; i++) begin
         step();
         check("idle.display", display, 1'b0);
         check_setups("idle", 1'b1, 1'b1, 1'b1);
      end

      // 2: sec/day press and release, each accepted after LAT edges
      btn_sec_day_raw = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
         step();
         check("sec.press", setup_second_day, (i < LAT) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check("sec.hold", setup_second_day, 1'b0);
      end
      btn_sec_day_raw = 1'b1;
      for (int i = 1; i <= LAT; i++) begin
         step();
         check("sec.release", setup_second_day, (i < LAT) ? 1'b0 : 1'b1);
      end

      // 3: bouncing display press, single pulse, nothing while held or on release
      for (int i = 0; i < 4; i++) begin
         btn_display_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
         step();
         check("disp.bounce", display, 1'b0);
      end
      btn_display_raw = 1'b0;
      for (int i = 1; i <= LAT + 1; i++) begin
         step();
         check("disp.pulse", display, (i == LAT + 1) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 50; i++) begin
         step();
         check("disp.held", display, 1'b0);
      end
      btn_display_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("disp.release", display, 1'b0);
      end

      // 4: a 3-cycle glitch on min/month never gets accepted
      btn_min_month_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("min.glitch", setup_minute_month, 1'b1);
      end
      btn_min_month_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("min.after", setup_minute_month, 1'b1);
      end

      // 5: all four pressed on the same edge
      btn_display_raw   = 1'b0;
      btn_sec_day_raw   = 1'b0;
      btn_min_month_raw = 1'b0;
      btn_hour_year_raw = 1'b0;
      for (int i = 1; i <= LAT + 2; i++) begin
         step();
         check("all.display", display, (i == LAT + 1) ? 1'b1 : 1'b0);
         if (i < LAT) check_setups("all.pre", 1'b1, 1'b1, 1'b1);
         else         check_setups("all.post", 1'b0, 1'b0, 1'b0);
      end
      btn_display_raw   = 1'b1;
      btn_sec_day_raw   = 1'b1;
      btn_min_month_raw = 1'b1;
      btn_hour_year_raw = 1'b1;
      for (int i = 1; i <= LAT + 4; i++) begin
         step();
         check("all.rel.display", display, 1'b0);
         if (i >= LAT) check_setups("all.rel", 1'b1, 1'b1, 1'b1);
      end

      // 6: hour/year held through a mid-count, mid-blink reset
      btn_hour_year_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hour.precount", setup_hour_year, 1'b1);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("hour.rst", setup_hour_year, 1'b1);
         check("hour.rst.display", display, 1'b0);
      end
      rst = 1'b0;
      for (int i = 1; i <= 2 * DIV; i++) begin
         step();
         check("hour.reaccept", setup_hour_year, (i < LAT) ? 1'b1 : 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_input_conditioner.md
Name: clock_input_conditioner

Overview:
Front-end stage that feeds control_unit. It takes four raw, bouncing, asynchronous push-button inputs and synchronizes and debounces each one. It then produces the strobes control_unit consumes: a single-cycle `display` press pulse, three debounced active-low `setup_*` levels (idle 1, pressed 0), and the periodic single-cycle `blink_tick`. One instance sits between the board pins and control_unit.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles needed to accept a level change (10 ms at 100 MHz); legal range >= 1.
BLINK_DIV, 50000000, period in clk cycles of blink_tick (0.5 s at 100 MHz); legal range >= 2.
RAW_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (pull-up board); 0 = read 1 when pressed.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
btn_display_raw  input  1  raw display/mode button, asynchronous
btn_sec_day_raw  input  1  raw second/day setup button, asynchronous
btn_min_month_raw  input  1  raw minute/month setup button, asynchronous
btn_hour_year_raw  input  1  raw hour/year setup button, asynchronous
display  output  1  one-cycle active-high pulse per accepted display press
setup_second_day  output  1  debounced level, active-low (0 = pressed)
setup_minute_month  output  1  debounced level, active-low
setup_hour_year  output  1  debounced level, active-low
blink_tick  output  1  one-cycle active-high pulse every BLINK_DIV cycles

Behaviour:
- Reset: all registers update only on rising clk while rst=1.
  - display=0, blink_tick=0, setup_*=1 (released).
  - Synchronizer flops are loaded with the "released" raw level.
  - Debounce counters are cleared; every channel's debounced state is "released"; the blink counter is 0.
- Synchronizer: a 2-flop chain per channel. Raw is normalized to pressed = 1 (inverted when RAW_ACTIVE_LOW=1), giving synchronized value s.
- Debounce, per channel: state d (pressed=1), counter cnt, sized $clog2(DEBOUNCE_CYCLES+1).
  - If s == d, then cnt <= 0.
  - Otherwise, cnt <= cnt+1.
  - When s != d and cnt == DEBOUNCE_CYCLES-1, then d <= s and cnt <= 0.
- Latency: a raw level held steady first sampled on edge k makes d change on edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: any return of s to d before acceptance clears cnt. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles never changes d.
- Outputs:
  - setup_* = ~d of the respective channel. These are registered levels with no extra latency beyond d.
  - display is registered: display <= d_disp & ~d_disp_prev. That gives exactly one pulse, one cycle after d_disp rises.
  - Release of the display button and holding it produce no further pulses. Re-press requires release to be accepted first.
- Blink: bcnt counts 0..BLINK_DIV-1 and wraps to 0.
  - blink_tick <= 1 on the cycle bcnt == BLINK_DIV-1, otherwise 0.
  - The first tick is asserted in the cycle after the BLINK_DIV-th rising edge after rst deasserts. After that, the period is exactly BLINK_DIV.
  - The blink counter is free-running and independent of the buttons.
- Simultaneous events: channels are fully independent. Any combination of simultaneous presses is accepted per channel with identical latency. A blink_tick coinciding with a press is unaffected.
- Reset mid-operation: partial debounce counts are discarded, no display pulse is emitted for the reset cycle, and the blink phase restarts.
  - A button held through reset is re-accepted DEBOUNCE_CYCLES+1 edges after rst falls. It then produces a display pulse if it is the display channel.

Decomposition:
- Package clock_input_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEF, BLINK_DIV_DEF;
  - channel index constants CH_DISP=0, CH_SEC=1, CH_MIN=2, CH_HOUR=3;
  - NUM_BTN=4.
- Sub-module btn_debounce, parameters DEBOUNCE_CYCLES and RAW_ACTIVE_LOW, with ports clk, rst, raw, pressed (d). It holds the synchronizer, counter and state.
- Top level: instantiates btn_debounce four times, plus the display edge detector, the setup inversion and the blink divider.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_DIV=8, RAW_ACTIVE_LOW=1, 10 ns clk):
1. rst=1 for 3 cycles, then 0, with all raw=1 -> display=0, setup_*=1, blink_tick=0 during reset. blink_tick pulses 1 cycle at 8, 16, 24 cycles after release.
2. btn_sec_day_raw=0 held from edge k -> setup_second_day falls at edge k+5 and stays 0. Raw back to 1 -> it returns to 1 five edges later.
3. btn_display_raw bounces 0,1,0,1 (1 cycle each), then stays 0 -> no change during the bounce. One display pulse, exactly 1 cycle wide, 6 edges after the final steady 0. No further pulse while held for 50 cycles.
4. btn_min_month_raw=0 for 3 cycles only -> setup_minute_month stays 1 throughout.
5. All four raw go to 0 on the same edge -> display pulse plus all three setup_* fall; each changes on the same edge it would when pressed alone.
6. btn_hour_year_raw held at 0, rst pulsed for 2 cycles mid-count and mid-blink -> setup_hour_year=1 during reset, falls 5 edges after rst drops. Next blink_tick comes 8 cycles after rst drops.
